// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD bus engine: opcodes, MODE fields,
// register-map bank bases, FSM encoding and the synchroniser bundle.
package simd_pkg;

  // Arithmetic operation carried in MODE[1:0].
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MAC = 2'd1,
    OP_MUL = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  // MODE register bit positions.
  localparam int MODE_OP_LSB     = 0;
  localparam int MODE_SIGNED_BIT = 2;

  // Register-map bases; bits [7:5] select the bank, [4:0] the element.
  localparam logic [7:0] BASE_A    = 8'h00;
  localparam logic [7:0] BASE_B    = 8'h20;
  localparam logic [7:0] BASE_MODE = 8'h40;
  localparam logic [7:0] BASE_C    = 8'h60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Asynchronous control pins, grouped so they share one synchroniser.
  typedef struct packed {
    logic cs;
    logic wr;
    logic rd;
    logic cd;
    logic ex;
  } ctl_t;

endpackage

// File: rtl/simd_lane.sv
// One combinational SIMD lane: extends the operands to 2*EW bits and
// applies add, multiply-accumulate, multiply or subtract.
module simd_lane
  import simd_pkg::*;
#(
  parameter int EW = 8
) (
  input  logic [EW-1:0]   a_i,
  input  logic [EW-1:0]   b_i,
  input  logic [EW-1:0]   c_i,
  input  op_e             op_i,
  input  logic            signed_i,
  output logic [2*EW-1:0] res_o
);

  logic [2*EW-1:0] a_x, b_x, c_x, prod;

  // Extend operands, then select the operation; 2*EW-bit modular
  // arithmetic on extended operands gives the exact signed/unsigned result.
  // NOTE: every output of a combinational block is assigned on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    a_x   = signed_i ? {{EW{a_i[EW-1]}}, a_i} : {{EW{1'b0}}, a_i};
    b_x   = signed_i ? {{EW{b_i[EW-1]}}, b_i} : {{EW{1'b0}}, b_i};
    c_x   = signed_i ? {{EW{c_i[EW-1]}}, c_i} : {{EW{1'b0}}, c_i};
    prod  = a_x * b_x;
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_x + b_x;
      OP_MAC:  res_o = prod + c_x;
      OP_MUL:  res_o = prod;
      OP_SUB:  res_o = a_x - b_x;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/simd_bus_engine.sv
// SIMD vector engine behind the Pico 8-bit parallel bus: synchronised
// strobes, A/B/C operand banks, LANES-wide compute and byte readback.
module simd_bus_engine
  import simd_pkg::*;
#(
  parameter int EW    = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic       cd,
  input  logic       execute,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

  localparam int NBEATS = DEPTH / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW     = 2 * EW;
  localparam int NBYTES = DEPTH * RW / 8;
  localparam int PW     = $clog2(NBYTES);
  localparam int BPE    = EW / 8;

  // ---------------- synchronisers and edge detect ----------------
  ctl_t       meta_q, sync_q;
  logic [7:0] din_meta_q, din_q;
  logic       wr_prev_q, rd_prev_q, ex_prev_q;

  // Two-flop synchronisers for pins and data, plus one history flop per strobe.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      din_meta_q <= '0;
      din_q      <= '0;
      wr_prev_q  <= 1'b0;
      rd_prev_q  <= 1'b0;
      ex_prev_q  <= 1'b0;
    end else begin
      meta_q     <= {cs, wr, rd, cd, execute};
      sync_q     <= meta_q;
      din_meta_q <= bus_din;
      din_q      <= din_meta_q;
      wr_prev_q  <= sync_q.wr;
      rd_prev_q  <= sync_q.rd;
      ex_prev_q  <= sync_q.ex;
    end
  end

  logic wr_rise, rd_fall, ex_rise;
  assign wr_rise = sync_q.cs & sync_q.wr & ~wr_prev_q;
  assign rd_fall = sync_q.cs & ~sync_q.rd & rd_prev_q;
  assign ex_rise = sync_q.cs & sync_q.ex & ~ex_prev_q;

  // ---------------- control FSM ----------------
  state_e         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           start, addr_wr, data_wr;

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign start   = ex_rise & ~busy;
  // Execute wins over a simultaneous address write.
  assign addr_wr = wr_rise & sync_q.cd & ~busy & ~start;
  assign data_wr = wr_rise & ~sync_q.cd & ~busy;

  // Next-state logic: IDLE -> RUN -> DONE, leaving DONE on execute or address write.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        beat_d  = '0;
      end
      ST_RUN: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(NBEATS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          beat_d  = '0;
        end else if (addr_wr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // ---------------- register map ----------------
  logic [7:0]    addr_q, addr_d;
  logic          byte_sel_q, byte_sel_d;
  logic [2:0]    mode_q, mode_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    elem_i, elem_nxt;
  logic [IW-1:0] eidx;
  logic          in_range, is_a, is_b, is_c, is_mode, is_elem, elem_done;

  assign elem_i    = addr_q[4:0];
  assign eidx      = elem_i[IW-1:0];
  assign in_range  = ({1'b0, elem_i} < 6'(DEPTH));
  assign is_a      = (addr_q[7:5] == BASE_A[7:5]) & in_range;
  assign is_b      = (addr_q[7:5] == BASE_B[7:5]) & in_range;
  assign is_c      = (addr_q[7:5] == BASE_C[7:5]) & in_range;
  assign is_mode   = (addr_q == BASE_MODE);
  assign is_elem   = is_a | is_b | is_c;
  assign elem_done = (BPE == 1) || byte_sel_q;
  assign elem_nxt  = (elem_i == 5'(DEPTH - 1)) ? 5'd0 : elem_i + 5'd1;

  // Address, byte toggle, MODE and read pointer next-state.
  always_comb begin
    addr_d     = addr_q;
    byte_sel_d = byte_sel_q;
    mode_d     = mode_q;
    rd_ptr_d   = rd_ptr_q;
    if (addr_wr) begin
      addr_d     = din_q;
      byte_sel_d = 1'b0;
    end else if (data_wr) begin
      if (is_mode) begin
        mode_d = din_q[2:0];
      end else if (is_elem) begin
        if (elem_done) begin
          byte_sel_d = 1'b0;
          addr_d     = {addr_q[7:5], elem_nxt};
        end else begin
          byte_sel_d = 1'b1;
        end
      end
    end
    if (start) rd_ptr_d = '0;
    else if (rd_fall && !busy) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Register-map state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      byte_sel_q <= 1'b0;
      mode_q     <= '0;
      rd_ptr_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      byte_sel_q <= byte_sel_d;
      mode_q     <= mode_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // ---------------- operand banks ----------------
  logic [EW-1:0] bank_a_q [DEPTH];
  logic [EW-1:0] bank_b_q [DEPTH];
  logic [EW-1:0] bank_c_q [DEPTH];

  function automatic logic [EW-1:0] put_byte(input logic [EW-1:0] old,
                                             input logic          sel,
                                             input logic [7:0]    b);
    logic [EW-1:0] r;
    r = old;
    for (int k = 0; k < BPE; k++) begin
      if (k == int'(sel)) r[k*8 +: 8] = b;
    end
    return r;
  endfunction

  // Byte-wide operand writes from the bus, little-endian within an element.
  // NOTE: these arrays carry a reset because the banks must read back as
  // zero after reset; that forces flops rather than RAM, acceptable at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_a_q[i] <= '0;
        bank_b_q[i] <= '0;
        bank_c_q[i] <= '0;
      end
    end else if (data_wr) begin
      if (is_a) bank_a_q[eidx] <= put_byte(bank_a_q[eidx], byte_sel_q, din_q);
      if (is_b) bank_b_q[eidx] <= put_byte(bank_b_q[eidx], byte_sel_q, din_q);
      if (is_c) bank_c_q[eidx] <= put_byte(bank_c_q[eidx], byte_sel_q, din_q);
    end
  end

  // ---------------- lanes and result buffer ----------------
  logic [IW-1:0] lane_idx [LANES];
  logic [EW-1:0] lane_a [LANES];
  logic [EW-1:0] lane_b [LANES];
  logic [EW-1:0] lane_c [LANES];
  logic [RW-1:0] lane_res [LANES];
  logic [RW-1:0] res_q [DEPTH];
  op_e           op;

  assign op = op_e'(mode_q[MODE_OP_LSB +: 2]);

  // Route the elements of the current beat to the lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = IW'(int'(beat_q) * LANES + l);
      lane_a[l]   = bank_a_q[lane_idx[l]];
      lane_b[l]   = bank_b_q[lane_idx[l]];
      lane_c[l]   = bank_c_q[lane_idx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    simd_lane #(.EW(EW)) u_lane (
      .a_i     (lane_a[l]),
      .b_i     (lane_b[l]),
      .c_i     (lane_c[l]),
      .op_i    (op),
      .signed_i(mode_q[MODE_SIGNED_BIT]),
      .res_o   (lane_res[l])
    );
  end

  // Each RUN beat stores LANES results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
    end else if (busy) begin
      for (int l = 0; l < LANES; l++) res_q[lane_idx[l]] <= lane_res[l];
    end
  end

  // ---------------- readback ----------------
  logic [DEPTH*RW-1:0] res_flat;
  logic [7:0]          rd_byte;
  logic [7:0]          bus_dout_q;
  logic                bus_oe_q;

  // Flatten results so element 0's least significant byte is byte 0.
  always_comb begin
    res_flat = '0;
    for (int e = 0; e < DEPTH; e++) res_flat[e*RW +: RW] = res_q[e];
  end

  assign rd_byte = res_flat[{rd_ptr_q, 3'b000} +: 8];

  // Registered bus outputs; reads return zero while computing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_dout_q <= '0;
      bus_oe_q   <= 1'b0;
    end else begin
      bus_dout_q <= busy ? 8'h00 : rd_byte;
      bus_oe_q   <= sync_q.cs & sync_q.rd;
    end
  end

  assign bus_dout = bus_dout_q;
  assign bus_oe   = bus_oe_q;

endmodule

// File: tb/tb_simd_bus_engine.sv
// Directed testbench for simd_bus_engine (EW=8, LANES=4, DEPTH=8).
module tb_simd_bus_engine;

  logic       clk = 1'b0;
  logic       rst_n, cs, wr, rd, cd, execute;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_oe, busy, done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_b [16];

  always #5 clk = ~clk;

  simd_bus_engine #(.EW(8), .LANES(4), .DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .wr      (wr),
    .rd      (rd),
    .cd      (cd),
    .execute (execute),
    .bus_din (bus_din),
    .bus_dout(bus_dout),
    .bus_oe  (bus_oe),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic is_addr, input logic [7:0] d);
    @(negedge clk);
    cd      = is_addr;
    bus_din = d;
    wr      = 1'b1;
    wait_clk(4);
    wr = 1'b0;
    wait_clk(4);
  endtask

  task automatic wr_addr(input logic [7:0] a);
    bus_write(1'b1, a);
  endtask

  task automatic wr_data(input logic [7:0] d);
    bus_write(1'b0, d);
  endtask

  // Pulse execute and count busy cycles over a fixed window.
  task automatic run_exec(input string tag);
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    execute = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (i == 2) execute = 1'b0;
    end
    check({tag, "_busy_cycles"}, busy_cycles, 2);
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_b[i] = 8'h00;
  endtask

  task automatic set_elem(input int e, input logic [15:0] v);
    exp_b[2*e]   = v[7:0];
    exp_b[2*e+1] = v[15:8];
  endtask

  // Read n bytes and compare each with the expected table (wrapping).
  task automatic read_expect(input string tag, input int n);
    logic [7:0] d;
    logic       oe;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd = 1'b1;
      wait_clk(5);
      d  = bus_dout;
      oe = bus_oe;
      rd = 1'b0;
      wait_clk(5);
      check($sformatf("%s_byte%0d", tag, i), d, exp_b[i % 16]);
      if (i == 0) check({tag, "_oe"}, oe, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; cd = 1'b0;
    execute = 1'b0; bus_din = 8'h00;
    wait_clk(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_oe", bus_oe, 1'b0);
    check("rst_dout", bus_dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(2);
    cs = 1'b1;
    wait_clk(3);

    // Unsigned add on the first three elements.
    wr_addr(8'h00); wr_data(8'd2); wr_data(8'd3); wr_data(8'd4);
    wr_addr(8'h20); wr_data(8'd5); wr_data(8'd6); wr_data(8'd7);
    wr_addr(8'h40); wr_data(8'h00);
    run_exec("add");
    clear_exp();
    set_elem(0, 16'h0007); set_elem(1, 16'h0009); set_elem(2, 16'h000B);
    read_expect("add", 16);

    // Address write leaves DONE; then multiply-accumulate with C = 1.
    wr_addr(8'h60);
    check("addr_clears_done", done, 1'b0);
    wr_data(8'd1); wr_data(8'd1); wr_data(8'd1);
    wr_addr(8'h40); wr_data(8'h01);
    run_exec("mac");
    clear_exp();
    set_elem(0, 16'h000B); set_elem(1, 16'h0013); set_elem(2, 16'h001D);
    read_expect("mac", 6);

    // 0xFF * 0x02 unsigned and signed.
    wr_addr(8'h00); wr_data(8'hFF);
    wr_addr(8'h20); wr_data(8'h02);
    wr_addr(8'h40); wr_data(8'h02);
    run_exec("mulu");
    clear_exp(); set_elem(0, 16'h01FE);
    read_expect("mulu", 2);
    wr_addr(8'h40); wr_data(8'h06);
    run_exec("muls");
    clear_exp(); set_elem(0, 16'hFFFE);
    read_expect("muls", 2);

    // Unsigned subtract going negative, then re-execute straight from DONE.
    wr_addr(8'h00); wr_data(8'd2);
    wr_addr(8'h20); wr_data(8'd5);
    wr_addr(8'h40); wr_data(8'h03);
    run_exec("sub");
    clear_exp(); set_elem(0, 16'hFFFD);
    read_expect("sub", 2);
    run_exec("sub_again");
    read_expect("sub_again", 2);

    // Nine writes from A[0]: the ninth wraps onto A[0]; 17th read wraps too.
    wr_addr(8'h40); wr_data(8'h00);
    wr_addr(8'h00);
    for (int i = 0; i < 9; i++) wr_data(8'h10 + 8'(i));
    run_exec("wrap");
    clear_exp();
    set_elem(0, 16'h001D); set_elem(1, 16'h0017); set_elem(2, 16'h0019);
    set_elem(3, 16'h0013); set_elem(4, 16'h0014); set_elem(5, 16'h0015);
    set_elem(6, 16'h0016); set_elem(7, 16'h0017);
    read_expect("wrap", 17);

    // Second execute and a data write to A[0] land while busy: both dropped.
    wr_addr(8'h00);
    begin
      int busy_cycles;
      busy_cycles = 0;
      @(negedge clk); execute = 1'b1;
      @(negedge clk); execute = 1'b0;
      @(negedge clk); execute = 1'b1; cd = 1'b0; bus_din = 8'hAA; wr = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (busy) busy_cycles++;
        if (i == 2) begin
          execute = 1'b0;
          wr      = 1'b0;
        end
      end
      check("busy_drop_cycles", busy_cycles, 2);
      check("busy_drop_done", done, 1'b1);
    end
    run_exec("busy_drop_rerun");
    read_expect("busy_drop", 1);

    // Reset in the middle of a run.
    @(negedge clk);
    execute = 1'b1;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("midrun_busy_seen", busy, 1'b1);
    rst_n   = 1'b0;
    execute = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    wait_clk(3);
    check("midrun_rst_oe", bus_oe, 1'b0);
    rst_n = 1'b1;
    wait_clk(3);
    clear_exp();
    read_expect("post_rst", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
